selftest_harness: RTL and testbench

//  Top-level self-checking harness under the simulation driver. It runs a built-in

---
 rtl/selftest_harness.sv | 131 +++++++++++++
 tb/tb_selftest_harness.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/selftest_harness.sv
// selftest_harness: built-in write/readback memory self-test.
// Fills an internal RAM with an LFSR pattern and reads it back for PASSES
// passes. Odd passes write the complemented pattern. io_success rises when
// every pass matches; io_failure rises on the first mismatch. Both are
// sticky until reset.
// Optional feature macro: HARNESS_ERR_INJECT_EN flips bit 0 of the pass-0
// word written to address DEPTH/2, so the readback must fail.
module selftest_harness #(
    parameter int          DEPTH  = 16,
    parameter int          WIDTH  = 32,
    parameter int          PASSES = 2,
    parameter logic [31:0] SEED   = 32'h1
) (
    input  logic clock,
    input  logic reset,
    output logic io_success,
    output logic io_failure
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          PW       = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] TAPS     = 32'h80200003;

    localparam logic [2:0] S_WRITE = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;

    logic [2:0]       state;
    logic [AW-1:0]    addr;
    logic [PW-1:0]    pass;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_next;
    // LFSR value at the start of the current pass; readback re-walks from here.
    logic [31:0]      pass_seed;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] exp_data;
    logic             rd_valid;
    logic             mismatch;
    logic             last_addr;

    // Galois LFSR step and the per-pass data pattern.
    always_comb begin
        lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
        pat       = pass[0] ? ~lfsr[WIDTH-1:0] : lfsr[WIDTH-1:0];
        last_addr = (addr == AW'(DEPTH - 1));
        mismatch  = rd_valid && (rd_data != exp_data);
    end

`ifdef HARNESS_ERR_INJECT_EN
    // Corrupt one pass-0 word so the readback comparison is forced to fail.
    always_comb begin
        wr_data = pat;
        if ((pass == '0) && (addr == AW'(DEPTH / 2)))
            wr_data = pat ^ WIDTH'(1);
    end
`else
    // Write data is the plain pattern.
    always_comb begin
        wr_data = pat;
    end
`endif

    // Synchronous single-port RAM: write in WRITE, registered read every cycle.
    always_ff @(posedge clock) begin
        if (reset && (state == S_WRITE))
            mem[addr] <= wr_data;
        rd_data <= mem[addr];
    end

    // Test sequencer: write pass, readback pass with one-cycle compare pipe.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_WRITE;
            addr       <= '0;
            pass       <= '0;
            lfsr       <= SEED_EFF;
            pass_seed  <= SEED_EFF;
            rd_valid   <= 1'b0;
            exp_data   <= '0;
            io_success <= 1'b0;
            io_failure <= 1'b0;
        end else begin
            rd_valid <= (state == S_READ) && !mismatch;
            exp_data <= pat;
            case (state)
                S_WRITE: begin
                    addr <= addr + AW'(1);
                    if (last_addr) begin
                        lfsr  <= pass_seed;
                        state <= S_READ;
                    end else begin
                        lfsr <= lfsr_next;
                    end
                end
                S_READ: begin
                    if (mismatch) begin
                        state      <= S_FAIL;
                        io_failure <= 1'b1;
                    end else begin
                        lfsr <= lfsr_next;
                        addr <= addr + AW'(1);
                        if (last_addr)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (mismatch) begin
                        state      <= S_FAIL;
                        io_failure <= 1'b1;
                    end else if (int'(pass) < PASSES - 1) begin
                        pass      <= pass + PW'(1);
                        pass_seed <= lfsr;
                        state     <= S_WRITE;
                    end else begin
                        state      <= S_DONE;
                        io_success <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_selftest_harness.sv
// Bench for selftest_harness: two instances (defaults, and a small
// DEPTH=4/WIDTH=8/PASSES=3/SEED=0 build) driven by random reset sequences.
// Expected output flags come from a cycle-count model of the test timing;
// RAM contents are checked against an LFSR sequence computed here.
module tb_selftest_harness;

    logic clock;
    logic reset;
    logic a_success, a_failure;
    logic b_success, b_failure;

`ifdef HARNESS_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    localparam int A_D = 16, A_P = 2;
    localparam int B_D = 4,  B_P = 3;

    selftest_harness dut_a (
        .clock(clock), .reset(reset),
        .io_success(a_success), .io_failure(a_failure)
    );

    selftest_harness #(.DEPTH(B_D), .WIDTH(8), .PASSES(B_P), .SEED(32'h0)) dut_b (
        .clock(clock), .reset(reset),
        .io_success(b_success), .io_failure(b_failure)
    );

    // Clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    logic [3:0] exp_q[$];
    logic [31:0] seq [64];

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    endfunction

    // Expected flags after `n` consecutive edges with reset released.
    function automatic logic [1:0] model(input int n, input int d, input int p);
        logic s, f;
        s = !INJ && (n >= p * (2 * d + 1));
        f = INJ && (n >= d + d / 2 + 2);
        return {s, f};
    endfunction

    // RAM content check at the end of a write phase of pass `p`.
    task automatic check_mem_a(input int p);
        logic [31:0] e;
        for (int i = 0; i < A_D; i++) begin
            e = seq[p * A_D + i];
            if (p % 2 == 1) e = ~e;
            if (INJ && p == 0 && i == A_D / 2) e = e ^ 32'h1;
            checks++;
            if (dut_a.mem[i] !== e) begin
                errors++;
                $display("FAIL mem_a p%0d[%0d]: got %h want %h", p, i, dut_a.mem[i], e);
            end
        end
    endtask

    task automatic check_mem_b(input int p);
        logic [7:0] e;
        for (int i = 0; i < B_D; i++) begin
            e = seq[p * B_D + i][7:0];
            if (p % 2 == 1) e = ~e;
            if (INJ && p == 0 && i == B_D / 2) e = e ^ 8'h1;
            checks++;
            if (dut_b.mem[i] !== e) begin
                errors++;
                $display("FAIL mem_b p%0d[%0d]: got %h want %h", p, i, dut_b.mem[i], e);
            end
        end
    endtask

    // Driver: drive reset for the next edge and push the expected flags.
    task automatic run_cycles(input int n, input logic rst);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (cyc == A_D) check_mem_a(0);
            if (!INJ && cyc == 2 * A_D + 1 + A_D) check_mem_a(1);
            if (cyc == B_D) check_mem_b(0);
            if (!INJ && cyc == 2 * B_D + 1 + B_D) check_mem_b(1);
            if (!INJ && cyc == 2 * (2 * B_D + 1) + B_D) check_mem_b(2);
            reset = rst;
            if (!rst) cyc = 0;
            else cyc++;
            exp_q.push_back({model(cyc, A_D, A_P), model(cyc, B_D, B_P)});
        end
    endtask

    // Monitor: pop one expectation per edge and compare the DUT flags.
    initial begin
        logic [3:0] e;
        logic [3:0] got;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {a_success, a_failure, b_success, b_failure};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL flags @t=%0t: got a_s/a_f/b_s/b_f=%b want %b", $time, got, e);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        seq[0] = 32'h1;
        for (int k = 1; k < 64; k++) seq[k] = lfsr_step(seq[k-1]);
        reset = 1'b0;
        run_cycles(3, 1'b0);
        // Plain run well past completion.
        run_cycles(72, 1'b1);
        // Long reset then full run.
        run_cycles(10, 1'b0);
        run_cycles(70, 1'b1);
        // Reset asserted mid-pass, then restart.
        run_cycles(2, 1'b0);
        run_cycles(39, 1'b1);
        run_cycles(5, 1'b0);
        run_cycles(70, 1'b1);
        // Random reset lengths and abort points.
        for (int t = 0; t < 8; t++) begin
            run_cycles($urandom_range(1, 12), 1'b0);
            run_cycles($urandom_range(1, 80), 1'b1);
        end
        run_cycles(2, 1'b0);
        run_cycles(70, 1'b1);
        repeat (2) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
